// File: rtl/pc_fetch_ctrl.sv
// RV32 fetch sequencer: owns the PC, issues one imem request at a time, holds the fetched word for decode.
// Optional misaligned-redirect trap is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc,
   output logic [31:0] retire_cnt,
   output logic        trap,
   output logic [31:0] trap_tval
);

   typedef enum logic [1:0] {BOOT, FETCH, DRAIN, DELIVER} state_t;

   state_t      state;
   logic [31:0] pend_pc;
   logic [31:0] tgt;

   function automatic logic [31:0] redirect_target(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
      redirect_target = (t[1:0] != 2'b00) ? TRAP_VEC : t;
`else
      redirect_target = {t[31:2], 2'b00};
`endif
   endfunction

   always_comb begin
      tgt = redirect_target(redirect_pc);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
         instr_valid <= 1'b0;
         instr       <= 32'd0;
         instr_pc    <= 32'd0;
         retire_cnt  <= 32'd0;
      end else begin
         case (state)
            BOOT: begin
               state     <= FETCH;
               imem_req  <= 1'b1;
               imem_addr <= pc;
            end
            FETCH: begin
               // A response that arrives with a redirect is stale; reissue at the target.
               if (redirect_valid && imem_rvalid) begin
                  pc        <= tgt;
                  imem_addr <= tgt;
               end else if (redirect_valid) begin
                  state <= DRAIN;
               end else if (imem_rvalid) begin
                  instr       <= imem_rdata;
                  instr_pc    <= pc;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  state       <= DELIVER;
               end
            end
            DRAIN: begin
               if (imem_rvalid) begin
                  pc        <= redirect_valid ? tgt : pend_pc;
                  imem_addr <= redirect_valid ? tgt : pend_pc;
                  state     <= FETCH;
               end
            end
            DELIVER: begin
               if (redirect_valid) begin
                  instr_valid <= 1'b0;
                  pc          <= tgt;
                  imem_req    <= 1'b1;
                  imem_addr   <= tgt;
                  state       <= FETCH;
               end else if (!stall) begin
                  instr_valid <= 1'b0;
                  pc          <= pc + 32'd4;
                  retire_cnt  <= retire_cnt + 32'd1;
                  imem_req    <= 1'b1;
                  imem_addr   <= pc + 32'd4;
                  state       <= FETCH;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

   // Redirect target held until the outstanding request drains; latest redirect wins.
   always_ff @(posedge clk) begin
      if ((state == FETCH || state == DRAIN) && redirect_valid)
         pend_pc <= tgt;
   end

`ifdef PC_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         trap      <= 1'b0;
         trap_tval <= 32'd0;
      end else begin
         trap <= 1'b0;
         if (redirect_valid && state != BOOT && redirect_pc[1:0] != 2'b00) begin
            trap      <= 1'b1;
            trap_tval <= redirect_pc;
         end
      end
   end
`else
   logic unused_trap_cfg;
   assign unused_trap_cfg = ^{TRAP_VEC, redirect_pc[1:0]};
   assign trap      = 1'b0;
   assign trap_tval = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: expected request addresses and deliveries are queued
// as stimulus is set up, then popped when the DUT issues a request or presents an instruction.
module tb_pc_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] pc;
   logic [31:0] retire_cnt;
   logic        trap;
   logic [31:0] trap_tval;

   int          n_chk = 0;
   int          n_fail = 0;
   int          resp_left = 0;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_deliv[$];
   logic        req_d = 1'b0;
   logic        rvalid_d = 1'b0;
   logic        ival_d = 1'b0;

   pc_fetch_ctrl dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .pc(pc), .retire_cnt(retire_cnt), .trap(trap), .trap_tval(trap_tval)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Memory model: answers a pending request in the same cycle, while the response budget lasts.
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (imem_rvalid) begin
            imem_rvalid = 1'b0;
         end else if (imem_req && resp_left > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(imem_addr);
            resp_left--;
         end
      end
   end

   // Scoreboard: new request = req rising, or req held after a completed handshake.
   always @(negedge clk) begin
      if (rst) begin
         if (imem_req && (!req_d || rvalid_d)) begin
            if (exp_addr.size() == 0) check_val("req_expected", 32'd0, 32'd1);
            else check_val("req_addr", imem_addr, exp_addr.pop_front());
         end
         if (instr_valid && !ival_d) begin
            if (exp_deliv.size() == 0) begin
               check_val("deliv_expected", 32'd0, 32'd1);
            end else begin
               logic [31:0] e;
               e = exp_deliv.pop_front();
               check_val("instr_pc", instr_pc, e);
               check_val("instr", instr, mem_word(e));
            end
         end
      end
      req_d    <= imem_req;
      rvalid_d <= imem_req && imem_rvalid;
      ival_d   <= instr_valid;
   end

   task automatic do_reset();
      rst = 1'b0;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      resp_left = 0;
      repeat (3) tick();
      exp_addr.delete();
      exp_deliv.delete();
      check_val("rst_req", {31'd0, imem_req}, 32'd0);
      check_val("rst_addr", imem_addr, 32'd0);
      check_val("rst_pc", pc, 32'd0);
      check_val("rst_ivalid", {31'd0, instr_valid}, 32'd0);
      check_val("rst_instr", instr, 32'd0);
      check_val("rst_instr_pc", instr_pc, 32'd0);
      check_val("rst_retire", retire_cnt, 32'd0);
      check_val("rst_trap", {31'd0, trap}, 32'd0);
      rst = 1'b1;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((exp_addr.size() != 0 || exp_deliv.size() != 0) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check_val({tag, "_timeout"}, 32'(exp_addr.size() + exp_deliv.size()), 32'd0);
   endtask

   task automatic wait_ivalid(input string tag);
      int n = 0;
      while (!instr_valid && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check_val({tag, "_timeout"}, {31'd0, instr_valid}, 32'd1);
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!imem_req && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check_val({tag, "_timeout"}, {31'd0, imem_req}, 32'd1);
   endtask

   task automatic pulse_redirect(input logic [31:0] t);
      redirect_valid = 1'b1;
      redirect_pc = t;
      tick();
      redirect_valid = 1'b0;
   endtask

   initial begin
      // 1: straight-line fetch, four instructions
      do_reset();
      for (int i = 0; i < 4; i++) begin
         exp_addr.push_back(32'(i * 4));
         exp_deliv.push_back(32'(i * 4));
      end
      exp_addr.push_back(32'h10);
      resp_left = 4;
      wait_drain("t1");
      check_val("t1_retire", retire_cnt, 32'd4);
      check_val("t1_pc", pc, 32'h10);

      // 2: stall holds the delivered instruction at pc 8
      do_reset();
      exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
      exp_deliv.push_back(32'h0); exp_deliv.push_back(32'h4);
      resp_left = 2;
      wait_drain("t2a");
      stall = 1'b1;
      exp_deliv.push_back(32'h8);
      resp_left = 1;
      wait_ivalid("t2");
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val("t2_ivalid", {31'd0, instr_valid}, 32'd1);
         check_val("t2_instr_pc", instr_pc, 32'h8);
         check_val("t2_instr", instr, mem_word(32'h8));
         check_val("t2_req", {31'd0, imem_req}, 32'd0);
         check_val("t2_pc", pc, 32'h8);
         check_val("t2_retire", retire_cnt, 32'd2);
      end
      exp_addr.push_back(32'hC);
      stall = 1'b0;
      wait_drain("t2b");
      check_val("t2_retire_after", retire_cnt, 32'd3);

      // 3: redirect while a request is outstanding drains the old response
      do_reset();
      exp_addr.push_back(32'h0);
      wait_req("t3");
      pulse_redirect(32'h200);
      for (int i = 0; i < 2; i++) begin
         check_val("t3_drain_req", {31'd0, imem_req}, 32'd1);
         check_val("t3_drain_addr", imem_addr, 32'h0);
         tick();
      end
      exp_addr.push_back(32'h200);
      resp_left = 1;
      wait_drain("t3a");
      tick();
      check_val("t3_no_ivalid", {31'd0, instr_valid}, 32'd0);
      exp_deliv.push_back(32'h200);
      exp_addr.push_back(32'h204);
      resp_left = 1;
      wait_drain("t3b");

      // 4: redirect beats stall in DELIVER
      do_reset();
      exp_addr.push_back(32'h0);
      exp_deliv.push_back(32'h0);
      stall = 1'b1;
      resp_left = 1;
      wait_ivalid("t4");
      exp_addr.push_back(32'h40);
      pulse_redirect(32'h40);
      check_val("t4_ivalid", {31'd0, instr_valid}, 32'd0);
      check_val("t4_retire", retire_cnt, 32'd0);
      check_val("t4_trap", {31'd0, trap}, 32'd0);
      stall = 1'b0;
      wait_drain("t4");
      check_val("t4_pc", pc, 32'h40);

      // 5: pc wraps past the top of the address space
      do_reset();
      exp_addr.push_back(32'h0);
      exp_deliv.push_back(32'h0);
      stall = 1'b1;
      resp_left = 1;
      wait_ivalid("t5");
      exp_addr.push_back(32'hFFFF_FFFC);
      pulse_redirect(32'hFFFF_FFFC);
      stall = 1'b0;
      exp_deliv.push_back(32'hFFFF_FFFC);
      exp_addr.push_back(32'h0);
      resp_left = 1;
      wait_drain("t5");
      check_val("t5_pc", pc, 32'h0);
      check_val("t5_retire", retire_cnt, 32'd1);

      // 6: misaligned redirect target
      do_reset();
      exp_addr.push_back(32'h0);
      exp_deliv.push_back(32'h0);
      stall = 1'b1;
      resp_left = 1;
      wait_ivalid("t6");
      exp_addr.push_back(32'h100);
      pulse_redirect(32'h102);
`ifdef PC_MISALIGN_TRAP_EN
      check_val("t6_trap", {31'd0, trap}, 32'd1);
      check_val("t6_tval", trap_tval, 32'h102);
`else
      check_val("t6_trap", {31'd0, trap}, 32'd0);
      check_val("t6_tval", trap_tval, 32'h0);
`endif
      tick();
      check_val("t6_trap_pulse", {31'd0, trap}, 32'd0);
      stall = 1'b0;
      wait_drain("t6");
      check_val("t6_pc", pc, 32'h100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
